// File: rtl/regf_access_ctrl_pkg.sv
// Shared processor definitions for the register-file access controller:
// default widths and the operand-fetch FSM state encoding.
package regf_access_ctrl_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2
  } regf_state_e;

endpackage : regf_access_ctrl_pkg

// File: rtl/regf_access_ctrl_scoreboard.sv
// Busy scoreboard: one bit per architectural register, set when a writer
// issues and cleared on its write-back; a same-cycle set beats the clear.
module regf_scoreboard
  import regf_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 set_i,
  input  logic [ADDR_W-1:0]    set_idx_i,
  input  logic                 clr_i,
  input  logic [ADDR_W-1:0]    clr_idx_i,
  output logic [2**ADDR_W-1:0] busy_o
);

  logic [2**ADDR_W-1:0] busy_q, busy_d;

  // NOTE: the set is applied after the clear so a new writer to the same
  // register keeps it busy; every bit gets a default first, so no latch.
  always_comb begin
    busy_d = busy_q;
    if (clr_i) busy_d[clr_idx_i] = 1'b0;
    if (set_i) busy_d[set_idx_i] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (clear) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule : regf_scoreboard

// File: rtl/regf_access_ctrl.sv
// Operand-fetch controller: hazard-checks issues against the busy scoreboard,
// reads the register file, forwards same-cycle write-backs and holds the bundle.
module regf_access_ctrl
  import regf_access_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              iss_valid,
  output logic              iss_ready,
  input  logic [ADDR_W-1:0] iss_rs_a,
  input  logic [ADDR_W-1:0] iss_rs_b,
  input  logic [ADDR_W-1:0] iss_rd,
  input  logic              iss_wen,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [ADDR_W-1:0] op_rd,
  output logic              op_wen,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [ADDR_W-1:0] rf_read_regA,
  output logic [ADDR_W-1:0] rf_read_regB,
  output logic              rf_rd,
  input  logic [DATA_W-1:0] rf_readA,
  input  logic [DATA_W-1:0] rf_readB,
  output logic [ADDR_W-1:0] rf_write_reg,
  output logic [DATA_W-1:0] rf_data,
  output logic              rf_wr
);

  regf_state_e          state_q, state_d;
  logic [ADDR_W-1:0]    rs_a_q, rs_a_d, rs_b_q, rs_b_d, rd_q, rd_d;
  logic                 wen_q, wen_d;
  logic [DATA_W-1:0]    op_a_q, op_a_d, op_b_q, op_b_d;
  logic [2**ADDR_W-1:0] busy;
  logic                 hazard, accept;

  regf_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
    .clk       (clk),
    .clear     (clear),
    .set_i     (accept & iss_wen),
    .set_idx_i (iss_rd),
    .clr_i     (wb_valid),
    .clr_idx_i (wb_rd),
    .busy_o    (busy)
  );

  assign hazard    = busy[iss_rs_a] | busy[iss_rs_b] | (iss_wen & busy[iss_rd]);
  assign iss_ready = (state_q == IDLE) & ~hazard & ~clear;
  assign accept    = iss_valid & iss_ready;

  assign rf_rd        = accept;
  assign rf_read_regA = iss_rs_a;
  assign rf_read_regB = iss_rs_b;

  assign rf_wr        = wb_valid & ~clear;
  assign rf_write_reg = wb_rd;
  assign rf_data      = wb_data;

  always_comb begin
    state_d = state_q;
    rs_a_d  = rs_a_q;
    rs_b_d  = rs_b_q;
    rd_d    = rd_q;
    wen_d   = wen_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    unique case (state_q)
      IDLE: if (accept) begin
        rs_a_d  = iss_rs_a;
        rs_b_d  = iss_rs_b;
        rd_d    = iss_rd;
        wen_d   = iss_wen;
        state_d = READ;
      end
      READ: begin
        // The register file returns pre-write data, so bypass a write-back landing now.
        op_a_d  = (wb_valid && wb_rd == rs_a_q) ? wb_data : rf_readA;
        op_b_d  = (wb_valid && wb_rd == rs_b_q) ? wb_data : rf_readB;
        state_d = HOLD;
      end
      HOLD: if (op_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= IDLE;
      rs_a_q  <= '0;
      rs_b_q  <= '0;
      rd_q    <= '0;
      wen_q   <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
    end else begin
      state_q <= state_d;
      rs_a_q  <= rs_a_d;
      rs_b_q  <= rs_b_d;
      rd_q    <= rd_d;
      wen_q   <= wen_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
    end
  end

  assign op_valid = (state_q == HOLD) & ~clear;
  assign op_a     = op_a_q;
  assign op_b     = op_b_q;
  assign op_rd    = rd_q;
  assign op_wen   = wen_q;

endmodule : regf_access_ctrl

// File: tb/tb_regf_access_ctrl.sv
// Directed bench for regf_access_ctrl with a behavioural register file that
// writes on rf_wr and returns read data one cycle after rf_rd.
module tb_regf_access_ctrl;

  logic        clk = 1'b0;
  logic        clear;
  logic        iss_valid, iss_ready, iss_wen;
  logic [4:0]  iss_rs_a, iss_rs_b, iss_rd;
  logic        op_valid, op_ready, op_wen;
  logic [31:0] op_a, op_b;
  logic [4:0]  op_rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  rf_read_regA, rf_read_regB, rf_write_reg;
  logic        rf_rd, rf_wr;
  logic [31:0] rf_readA, rf_readB, rf_data;
  logic [31:0] rf_mem [32];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  regf_access_ctrl dut (
    .clk          (clk),
    .clear        (clear),
    .iss_valid    (iss_valid),
    .iss_ready    (iss_ready),
    .iss_rs_a     (iss_rs_a),
    .iss_rs_b     (iss_rs_b),
    .iss_rd       (iss_rd),
    .iss_wen      (iss_wen),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .op_a         (op_a),
    .op_b         (op_b),
    .op_rd        (op_rd),
    .op_wen       (op_wen),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .rf_read_regA (rf_read_regA),
    .rf_read_regB (rf_read_regB),
    .rf_rd        (rf_rd),
    .rf_readA     (rf_readA),
    .rf_readB     (rf_readB),
    .rf_write_reg (rf_write_reg),
    .rf_data      (rf_data),
    .rf_wr        (rf_wr)
  );

  always @(posedge clk) begin
    if (rf_wr) rf_mem[rf_write_reg] <= rf_data;
    if (rf_rd) begin
      rf_readA <= rf_mem[rf_read_regA];
      rf_readB <= rf_mem[rf_read_regB];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] d, input logic w);
    iss_valid = 1'b1;
    iss_rs_a  = a;
    iss_rs_b  = b;
    iss_rd    = d;
    iss_wen   = w;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] v);
    wb_valid = 1'b1;
    wb_rd    = r;
    wb_data  = v;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'h0;
    rf_readA  = '0;
    rf_readB  = '0;
    clear     = 1'b1;
    iss_valid = 1'b0;
    iss_rs_a  = '0;
    iss_rs_b  = '0;
    iss_rd    = '0;
    iss_wen   = 1'b0;
    op_ready  = 1'b0;
    wb_valid  = 1'b0;
    wb_rd     = '0;
    wb_data   = '0;
    tick();
    tick();
    clear = 1'b0;
    #1;
    chk("reset_op_valid", op_valid, 0);
    chk("reset_iss_ready", iss_ready, 1);
    chk("reset_op_a", op_a, 0);
    chk("reset_rf_rd", rf_rd, 0);

    // Write r0 and r5, then read both back.
    wb(5'd0, 32'h123ABC01);
    #1;
    chk("wr_rf_wr", rf_wr, 1);
    chk("wr_reg", rf_write_reg, 0);
    chk("wr_data", rf_data, 32'h123ABC01);
    tick();
    wb(5'd5, 32'hAAAABCAA);
    tick();
    wb_valid = 1'b0;
    issue(5'd0, 5'd5, 5'd1, 1'b0);
    #1;
    chk("rd_iss_ready", iss_ready, 1);
    chk("rd_rf_rd", rf_rd, 1);
    chk("rd_regA", rf_read_regA, 0);
    chk("rd_regB", rf_read_regB, 5);
    tick();
    iss_valid = 1'b0;
    #1;
    chk("rd_read_rf_rd", rf_rd, 0);
    chk("rd_read_op_valid", op_valid, 0);
    chk("rd_read_iss_ready", iss_ready, 0);
    tick();
    chk("rd_op_valid", op_valid, 1);
    chk("rd_op_a", op_a, 32'h123ABC01);
    chk("rd_op_b", op_b, 32'hAAAABCAA);
    chk("rd_op_rd", op_rd, 1);
    chk("rd_op_wen", op_wen, 0);
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    chk("rd_back_idle", op_valid, 0);

    // Back-pressure: bundle and outputs held while op_ready is low.
    issue(5'd5, 5'd0, 5'd2, 1'b0);
    tick();
    iss_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("bp_op_valid", op_valid, 1);
      chk("bp_op_a", op_a, 32'hAAAABCAA);
      chk("bp_op_b", op_b, 32'h123ABC01);
      chk("bp_iss_ready", iss_ready, 0);
      tick();
    end
    op_ready = 1'b1;
    #1;
    chk("bp_release_valid", op_valid, 1);
    tick();
    chk("bp_idle", op_valid, 0);
    chk("bp_idle_ready", iss_ready, 1);

    // RAW stall: writer of r5 in flight, reader of r5 waits for write-back.
    issue(5'd0, 5'd0, 5'd5, 1'b1);
    tick();
    iss_valid = 1'b0;
    tick();
    chk("raw_w_op_wen", op_wen, 1);
    chk("raw_w_op_rd", op_rd, 5);
    tick();
    issue(5'd5, 5'd0, 5'd6, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("raw_stall", iss_ready, 0);
      tick();
    end
    wb(5'd5, 32'h00000042);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("raw_ready", iss_ready, 1);
    tick();
    iss_valid = 1'b0;
    tick();
    chk("raw_op_valid", op_valid, 1);
    chk("raw_op_a", op_a, 32'h00000042);
    chk("raw_op_b", op_b, 32'h123ABC01);
    tick();

    // Forwarding: write-back of r3 during the READ cycle.
    issue(5'd0, 5'd3, 5'd0, 1'b0);
    tick();
    iss_valid = 1'b0;
    wb(5'd3, 32'h0000BEEF);
    tick();
    wb_valid = 1'b0;
    chk("fwd_op_b", op_b, 32'h0000BEEF);
    chk("fwd_op_a", op_a, 32'h123ABC01);
    tick();

    // WAW with set-over-clear on r7.
    wb(5'd7, 32'h00000011);
    issue(5'd0, 5'd0, 5'd7, 1'b1);
    #1;
    chk("waw_first_ready", iss_ready, 1);
    tick();
    wb_valid  = 1'b0;
    iss_valid = 1'b0;
    tick();
    tick();
    issue(5'd1, 5'd2, 5'd7, 1'b1);
    #1;
    chk("waw_stall0", iss_ready, 0);
    tick();
    chk("waw_stall1", iss_ready, 0);
    wb(5'd7, 32'h00000077);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("waw_ready", iss_ready, 1);
    tick();
    iss_valid = 1'b0;
    tick();
    chk("waw_op_rd", op_rd, 7);
    chk("waw_op_wen", op_wen, 1);

    // Clear held 5 cycles while a bundle sits in HOLD (r7 still busy).
    op_ready = 1'b0;
    tick();
    chk("clr_pre_hold", op_valid, 1);
    clear = 1'b1;
    issue(5'd0, 5'd0, 5'd1, 1'b0);
    wb(5'd9, 32'hDEADBEEF);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("clr_iss_ready", iss_ready, 0);
      chk("clr_rf_rd", rf_rd, 0);
      chk("clr_rf_wr", rf_wr, 0);
      tick();
      chk("clr_op_valid", op_valid, 0);
      chk("clr_op_a", op_a, 0);
      chk("clr_op_rd", op_rd, 0);
      chk("clr_op_wen", op_wen, 0);
    end
    clear     = 1'b0;
    wb_valid  = 1'b0;
    iss_valid = 1'b0;
    iss_rd    = 5'd7;
    iss_wen   = 1'b1;
    #1;
    chk("clr_after_ready", iss_ready, 1);
    chk("clr_after_valid", op_valid, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_regf_access_ctrl
